// File: rtl/fifo_pkg.sv
// fifo_pkg: FSM state encoding and output-buffer sizing shared by the FIFO read streamer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  // Output buffer entries; pointer wrap in fifo_skid_buf assumes a power of two.
  localparam int BUF_DEPTH = 2;
  localparam int BUF_CW    = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: small circular output buffer (BUF_DEPTH entries) between FIFO read and stream.
// Latency: push on edge N -> visible on pop_dat / count from N+1; pop_dat is a direct register read.
// Backpressure: none internally; caller must not push when full nor pop when empty.
//
// Ports: clk/rst (sync, active-high); push + push_dat write one entry; pop retires the head;
//        pop_dat shows the head entry; count is current occupancy. Push and pop may coincide.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DSIZE-1:0]  push_dat,
  input  logic              pop,
  output logic [DSIZE-1:0]  pop_dat,
  output logic [BUF_CW-1:0] count
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DSIZE-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Entries are cleared too so the stream data bus reads zero out of reset.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: reads a burst (or continuous run) from a FIFO and presents it as a valid/ready stream.
// Latency: fifo_ren in cycle N -> m_valid in N+1 (FALLTHROUGH="TRUE") or N+2 (registered-read FIFO).
// Backpressure: m_ready low fills a 2-entry buffer, then fifo_ren is withheld; no word is dropped.
//
// Ports: rclk, rrst (sync, active-high); start/stop/burst_len control (burst_len 0 = run until stop);
//        fifo_ren/fifo_rdata/fifo_empty to the FIFO; m_valid/m_ready/m_data downstream;
//        busy (READ or FLUSH), done (1-cycle pulse), rd_count (words delivered this burst, saturating).
// Build option: define FIFO_RD_STREAM_ERRCHK_EN to add a sticky err output for protocol violations.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int    DSIZE       = 8,
  parameter int    ASIZE       = 4,
  parameter string FALLTHROUGH = "TRUE"
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             start,
  input  logic             stop,
  input  logic [ASIZE:0]   burst_len,
  output logic             fifo_ren,
  input  logic [DSIZE-1:0] fifo_rdata,
  input  logic             fifo_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             busy,
  output logic             done,
  output logic [ASIZE:0]   rd_count
`ifdef FIFO_RD_STREAM_ERRCHK_EN
  ,
  output logic             err
`endif
);

  localparam bit                FWFT     = (FALLTHROUGH == "TRUE");
  localparam logic [BUF_CW:0]   HELD_MAX = (BUF_CW + 1)'(BUF_DEPTH);
  localparam logic [ASIZE:0]    LEN_ONE  = (ASIZE + 1)'(1);

  rd_state_e         state;
  rd_state_e         state_nxt;
  logic [ASIZE:0]    remaining;
  logic              cont;
  logic              infl;      // registered-read FIFO: data for last cycle's read arrives now
  logic              push;
  logic              pop;
  logic [BUF_CW-1:0] count;
  logic [BUF_CW:0]   held_nxt;
  logic              accept;

  assign pop     = m_valid && m_ready;
  assign m_valid = (count != '0);
  assign push    = FWFT ? fifo_ren : infl;
  assign accept  = (state == IDLE) && start && !stop;

  // Entries still held after this edge, before counting any read issued now. Crediting the
  // departing word is what lets a registered-read FIFO sustain one word per cycle.
  assign held_nxt = {1'b0, count} + {{BUF_CW{1'b0}}, infl} - {{BUF_CW{1'b0}}, pop};

  always_comb begin
    state_nxt = state;
    fifo_ren  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = READ;
        end
      end
      READ: begin
        busy     = 1'b1;
        // rrst gating keeps the external FIFO intact when the burst is being torn down.
        fifo_ren = !rrst && !stop && !fifo_empty && (cont || (remaining != '0))
                   && (held_nxt < HELD_MAX);
        // Leave as soon as the last read issues so done lands right after the last transfer.
        if (stop || (!cont && ((remaining == '0) || ((remaining == LEN_ONE) && fifo_ren)))) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (held_nxt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state     <= IDLE;
      remaining <= '0;
      cont      <= 1'b0;
      infl      <= 1'b0;
      rd_count  <= '0;
    end else begin
      state <= state_nxt;
      infl  <= !FWFT && fifo_ren;
      if (accept) begin
        remaining <= burst_len;
        cont      <= (burst_len == '0);
        rd_count  <= '0;
      end else begin
        if (fifo_ren && !cont) begin
          remaining <= remaining - 1'b1;
        end
        if (pop && (rd_count != '1)) begin
          rd_count <= rd_count + 1'b1;
        end
      end
    end
  end

  fifo_skid_buf #(
    .DSIZE (DSIZE)
  ) u_buf (
    .clk      (rclk),
    .rst      (rrst),
    .push     (push),
    .push_dat (fifo_rdata),
    .pop      (pop),
    .pop_dat  (m_data),
    .count    (count)
  );

`ifdef FIFO_RD_STREAM_ERRCHK_EN
  logic [DSIZE-1:0] m_data_q;
  logic             stall_q;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      err      <= 1'b0;
      stall_q  <= 1'b0;
      m_data_q <= '0;
    end else begin
      stall_q  <= m_valid && !m_ready;
      m_data_q <= m_data;
      if ((fifo_ren && fifo_empty) || (stall_q && (m_data != m_data_q))) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: drives a FWFT instance (index 0) and a registered-read instance (index 1)
// from shared control, each with its own FIFO model; a negedge monitor scores the streams.
// Latency: n/a. Backpressure: m_ready is shared and driven by the stimulus.
module tb_fifo_rd_stream;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;

  logic rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic             rrst;
  logic             start;
  logic             stop;
  logic             m_ready;
  logic             fifo_clr;
  logic [ASIZE:0]   burst_len;
  logic [1:0]       fifo_ren;
  logic [1:0]       fifo_empty;
  logic [1:0]       m_valid;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [DSIZE-1:0] rdata_f;
  logic [DSIZE-1:0] rdata_s;
  logic [DSIZE-1:0] m_data [2];
  logic [ASIZE:0]   rd_count [2];

  fifo_rd_stream #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FALLTHROUGH("TRUE")) u_fwft (
    .rclk(rclk), .rrst(rrst), .start(start), .stop(stop), .burst_len(burst_len),
    .fifo_ren(fifo_ren[0]), .fifo_rdata(rdata_f), .fifo_empty(fifo_empty[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
    .busy(busy[0]), .done(done[0]), .rd_count(rd_count[0])
  );

  fifo_rd_stream #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FALLTHROUGH("FALSE")) u_sync (
    .rclk(rclk), .rrst(rrst), .start(start), .stop(stop), .burst_len(burst_len),
    .fifo_ren(fifo_ren[1]), .fifo_rdata(rdata_s), .fifo_empty(fifo_empty[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
    .busy(busy[1]), .done(done[1]), .rd_count(rd_count[1])
  );

  // ---------------- FIFO models (shared contents, private read pointers) ----------------
  logic [DSIZE-1:0] mem [64];
  logic [5:0]       wr_idx;
  logic [5:0]       rd_idx [2];
  int               nfetch [2] = '{0, 0};
  int               cyc = 0;

  assign fifo_empty[0] = (rd_idx[0] == wr_idx);
  assign fifo_empty[1] = (rd_idx[1] == wr_idx);
  assign rdata_f       = mem[rd_idx[0]];

  always @(posedge rclk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (fifo_clr) begin
        rd_idx[i] <= wr_idx;
      end else if (fifo_ren[i]) begin
        rd_idx[i] <= rd_idx[i] + 6'd1;
        nfetch[i] <= nfetch[i] + 1;
      end
    end
    if (fifo_ren[1]) rdata_s <= mem[rd_idx[1]];
  end

  // ---------------- scoreboard ----------------
  logic [DSIZE-1:0] exp_q0 [$];
  logic [DSIZE-1:0] exp_q1 [$];
  logic [DSIZE-1:0] exp_w;
  logic [DSIZE-1:0] hold_dat [2];
  logic [5:0]       left_w;
  int n_chk  = 0;
  int n_pass = 0;
  int nxfer [2];
  int first_ren [2];
  int first_vld [2];
  int last_xfer [2];
  int done_cyc [2];
  int done_seen [2];
  int hold_prev [2] = '{0, 0};
  int base_fetch [2];
  int snap [2];

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, req);
  endtask

  always @(negedge rclk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i] && fifo_empty[i]) chk($sformatf("ren_while_empty%0d", i), fifo_ren[i], 0);
      if (fifo_ren[i] && first_ren[i] < 0) first_ren[i] = cyc;
      if (m_valid[i] && first_vld[i] < 0) first_vld[i] = cyc;
      if (hold_prev[i] != 0 && m_valid[i]) chk($sformatf("hold%0d", i), m_data[i], hold_dat[i]);
      if (m_valid[i] && m_ready) begin
        if (i == 0) begin
          chk("word_expected0", exp_q0.size() > 0, 1);
          if (exp_q0.size() > 0) begin
            exp_w = exp_q0.pop_front();
            chk("data0", m_data[0], exp_w);
          end
        end else begin
          chk("word_expected1", exp_q1.size() > 0, 1);
          if (exp_q1.size() > 0) begin
            exp_w = exp_q1.pop_front();
            chk("data1", m_data[1], exp_w);
          end
        end
        nxfer[i]++;
        last_xfer[i] = cyc;
      end
      hold_prev[i] = (m_valid[i] && !m_ready) ? 1 : 0;
      hold_dat[i]  = m_data[i];
      if (done[i]) begin
        done_seen[i] = 1;
        done_cyc[i]  = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic load(input int n, input logic [DSIZE-1:0] base);
    for (int k = 0; k < n; k++) begin
      mem[wr_idx] = base + DSIZE'(k);
      exp_q0.push_back(base + DSIZE'(k));
      exp_q1.push_back(base + DSIZE'(k));
      wr_idx = wr_idx + 6'd1;
    end
  endtask

  task automatic arm();
    for (int i = 0; i < 2; i++) begin
      nxfer[i] = 0; first_ren[i] = -1; first_vld[i] = -1;
      last_xfer[i] = -1; done_seen[i] = 0; done_cyc[i] = -1;
      base_fetch[i] = nfetch[i];
    end
  endtask

  task automatic kick(input int len);
    burst_len = (ASIZE + 1)'(len);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!(done_seen[0] != 0 && done_seen[1] != 0) && c < budget) begin
      step(1);
      c++;
    end
    chk("done_reached", (done_seen[0] != 0) && (done_seen[1] != 0), 1);
  endtask

  task automatic drain_fifos();
    fifo_clr = 1'b1;
    step(1);
    fifo_clr = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_ren%0d", tag, i), fifo_ren[i], 0);
      chk($sformatf("%s_valid%0d", tag, i), m_valid[i], 0);
      chk($sformatf("%s_data%0d", tag, i), m_data[i], 0);
      chk($sformatf("%s_busy%0d", tag, i), busy[i], 0);
      chk($sformatf("%s_done%0d", tag, i), done[i], 0);
      chk($sformatf("%s_count%0d", tag, i), rd_count[i], 0);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rrst = 1'b1; start = 1'b0; stop = 1'b0; m_ready = 1'b1;
    burst_len = '0; fifo_clr = 1'b1; wr_idx = '0;
    step(3);
    fifo_clr = 1'b0;
    chk_reset_outs("reset");
    rrst = 1'b0;
    step(1);

    // 8-word burst, free-running sink: latency, back-to-back words, done timing.
    arm(); load(8, 8'h10); kick(8); wait_done(60);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("latency%0d", i), first_vld[i] - first_ren[i], (i == 0) ? 1 : 2);
      chk($sformatf("b8_words%0d", i), nxfer[i], 8);
      chk($sformatf("b8_back2back%0d", i), last_xfer[i] - first_vld[i], 7);
      chk($sformatf("b8_done_gap%0d", i), done_cyc[i] - last_xfer[i], 1);
      chk($sformatf("b8_rd_count%0d", i), rd_count[i], 8);
    end
    chk("b8_left0", exp_q0.size(), 0);
    chk("b8_left1", exp_q1.size(), 0);
    step(2);

    // Sink stalls 5 cycles mid-burst; a start during the burst must be ignored.
    arm(); load(10, 8'h40); kick(10); step(3);
    m_ready = 1'b0;
    step(2);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("stall_ren%0d", i), fifo_ren[i], 0);
        chk($sformatf("stall_valid%0d", i), m_valid[i], 1);
        chk($sformatf("stall_held%0d", i), (nfetch[i] - base_fetch[i] - nxfer[i]) <= 2, 1);
      end
      if (k == 1) begin
        burst_len = 5'd3;
        start = 1'b1;
      end
      step(1);
      start = 1'b0;
    end
    m_ready = 1'b1;
    wait_done(60);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("stall_rd_count%0d", i), rd_count[i], 10);
      chk($sformatf("stall_words%0d", i), nxfer[i], 10);
    end
    chk("stall_left0", exp_q0.size(), 0);
    chk("stall_left1", exp_q1.size(), 0);
    step(2);

    // FIFO runs dry after 3 of 6 words, refilled 10 cycles later.
    arm(); load(3, 8'h60); kick(6);
    for (int c = 0; c < 30 && !(fifo_empty == 2'b11 && nfetch[1] - base_fetch[1] == 3); c++) step(1);
    chk("dry_reached", fifo_empty == 2'b11, 1);
    step(10);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dry_words%0d", i), nxfer[i], 3);
      chk($sformatf("dry_busy%0d", i), busy[i], 1);
    end
    load(3, 8'h63);
    wait_done(60);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dry_rd_count%0d", i), rd_count[i], 6);
      chk($sformatf("dry_total%0d", i), nxfer[i], 6);
    end
    chk("dry_left0", exp_q0.size(), 0);
    chk("dry_left1", exp_q1.size(), 0);
    step(2);

    // Continuous burst stopped after 5 transfers: in-flight words still delivered.
    arm(); load(20, 8'h80); kick(0);
    for (int c = 0; c < 30 && nxfer[0] < 5; c++) step(1);
    chk("stop_reached", nxfer[0] >= 5, 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    wait_done(30);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("stop_rd_count%0d", i), rd_count[i], nxfer[i]);
      left_w = wr_idx - rd_idx[i];
      chk($sformatf("stop_no_loss%0d", i), (i == 0) ? exp_q0.size() : exp_q1.size(), left_w);
      snap[i] = nfetch[i];
    end
    step(5);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("stop_no_reads%0d", i), nfetch[i] - snap[i], 0);
      chk($sformatf("stop_idle%0d", i), busy[i], 0);
    end
    drain_fifos();

    // start and stop together in IDLE start nothing.
    arm(); load(2, 8'hA0);
    burst_len = 5'd2; start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 2; i++) chk($sformatf("startstop_busy%0d", i), busy[i], 0);
    step(2);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("startstop_reads%0d", i), nfetch[i] - base_fetch[i], 0);
      chk($sformatf("startstop_idle%0d", i), busy[i], 0);
    end
    drain_fifos();

    // Reset mid-burst with words buffered: outputs return to reset values, no done.
    arm(); load(6, 8'hC0); kick(6); step(2);
    m_ready = 1'b0;
    step(3);
    for (int i = 0; i < 2; i++) chk($sformatf("pre_rst_valid%0d", i), m_valid[i], 1);
    rrst = 1'b1;
    step(1);
    chk_reset_outs("midrst");
    rrst = 1'b0;
    step(3);
    for (int i = 0; i < 2; i++) chk($sformatf("midrst_no_done%0d", i), done_seen[i], 0);
    drain_fifos();
    m_ready = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width.
REQ-002 SHALL have parameter ASIZE, default 4, FIFO address bits; DEPTH = 1<<ASIZE.
REQ-003 SHALL have parameter FALLTHROUGH, default "TRUE"; "TRUE" means fifo_rdata is valid whenever !fifo_empty, anything else means fifo_rdata is valid one cycle after fifo_ren.
REQ-004 SHALL have rclk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have rrst  input  1  synchronous, active-high reset.
REQ-006 SHALL have start  input  1  one-cycle burst request, sampled in IDLE only.
REQ-007 SHALL have stop  input  1  terminates the active burst; no further reads are issued.
REQ-008 SHALL have burst_len  input  ASIZE+1  words to read, latched on start; 0 = continuous until stop.
REQ-009 SHALL have fifo_ren  output  1  FIFO read enable.
REQ-010 SHALL have fifo_rdata  input  DSIZE  FIFO read data.
REQ-011 SHALL have fifo_empty  input  1  FIFO empty flag.
REQ-012 SHALL have m_valid / m_ready / m_data  output / input / output  1 / 1 / DSIZE  downstream stream handshake.
REQ-013 SHALL have busy  output  1  high in READ and FLUSH.
REQ-014 SHALL have done  output  1  one-cycle pulse at burst completion.
REQ-015 SHALL have rd_count  output  ASIZE+1  words delivered on m_* in the current burst.

Function
REQ-016 SHALL implement FSM IDLE -> READ (start) -> FLUSH (remaining==0 or stop) -> DONE (output buffer empty, no read in flight) -> IDLE (unconditional, one cycle).
REQ-017 SHALL assert fifo_ren only in READ, only when !fifo_empty, remaining!=0 (or continuous), and buffer occupancy + reads in flight < 2.
REQ-018 SHALL capture fifo_rdata into a 2-entry output buffer: FWFT mode on the edge ending the fifo_ren cycle; sync mode one edge later.
REQ-019 SHALL give latency fifo_ren cycle N -> m_valid at N+1 (FWFT) or N+2 (sync), with m_ready held high.
REQ-020 SHALL hold m_valid and m_data stable until m_valid && m_ready; a transfer and a capture in the same cycle SHALL both take effect.
REQ-021 SHALL sustain one word per cycle when !fifo_empty and m_ready stay high.
REQ-022 SHALL decrement remaining by one per fifo_ren and increment rd_count (saturating at 2^(ASIZE+1)-1) per m_* transfer.
REQ-023 SHALL stall in READ with fifo_ren low while fifo_empty, resuming on the first cycle it deasserts.
REQ-024 SHALL ignore start outside IDLE; start and stop together in IDLE SHALL start nothing.
REQ-025 SHALL deliver already-fetched and in-flight words in FLUSH before done.
REQ-026 SHALL never assert fifo_ren while fifo_empty.

Reset
REQ-027 SHALL, on rrst, go to IDLE with fifo_ren=0, m_valid=0, m_data=0, busy=0, done=0, rd_count=0, remaining=0, buffer and in-flight flag cleared.
REQ-028 SHALL discard buffered data when rrst occurs mid-burst and emit no done.

Configuration
REQ-029 SHALL, with FIFO_RD_STREAM_ERRCHK_EN defined, add output err (1 bit, sticky until rrst) set on a read issued while fifo_empty or an m_data change while m_valid && !m_ready.
REQ-030 SHALL, without FIFO_RD_STREAM_ERRCHK_EN, have no err port and no checking logic.

Structure
REQ-031 SHALL take the FSM state enum (IDLE, READ, FLUSH, DONE) and the buffer depth constant (2) from shared package fifo_pkg.
REQ-032 SHALL implement the 2-entry output buffer as sub-module fifo_skid_buf (DSIZE parameter, push/pop/count).

Verification
REQ-033 SHALL be covered by: FWFT mode, FIFO holds 8 words, burst_len=8, m_ready=1 -> 8 consecutive m_valid cycles in FIFO order, done 1 cycle after last transfer, rd_count=8.
REQ-034 SHALL be covered by: sync mode, burst_len=4 -> first m_valid 2 cycles after first fifo_ren; 4 words, then done.
REQ-035 SHALL be covered by: m_ready low for 5 cycles mid-burst -> at most 2 words buffered, fifo_ren low, m_data stable, no loss.
REQ-036 SHALL be covered by: FIFO empties after 3 of 6 words, refilled 10 cycles later -> fifo_ren low while empty, 6 words delivered total.
REQ-037 SHALL be covered by: burst_len=0, stop after 5 transfers -> in-flight words flushed, done pulses, no further fifo_ren.
REQ-038 SHALL be covered by: rrst in READ with buffered data -> all outputs at reset values next cycle, no done.
